relu_drain_fifo_l4: RTL and testbench

Layer-4 output stage directly downstream of the 4-input multiply/adder-tree array. It captures each M-channel filter result vector, applies optional ReLU, and buffers up to DEPTH vectors. It then drains them one 16-bit channel word per cycle over a valid/ready stream toward the feature-map write path. The array upstream cannot stall, so overflow is detected and flagged rather than back-pressured.

---
 rtl/l4_pkg.sv | 30 +++
 rtl/vec_fifo_l4.sv | 75 +++++++
 rtl/relu_drain_fifo_l4.sv | 109 ++++++++++
 tb/tb_relu_drain_fifo_l4.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/l4_pkg.sv
// Shared definitions for the layer-4 datapath: word width, channel-index width
// and the per-word ReLU clamp applied on buffer write.
package l4_pkg;

   localparam int DATA_W = 16;

   // Width of a channel index for an M-channel vector (at least one bit)
   function automatic int ch_w(input int m);
      int w_res;
      if (m > 1) begin
         w_res = $clog2(m);
      end else begin
         w_res = 1;
      end
      return w_res;
   endfunction

   // Negative words become zero when the clamp is enabled
   function automatic logic [DATA_W-1:0] relu_word(input logic [DATA_W-1:0] w_in,
                                                   input logic             w_en);
      logic [DATA_W-1:0] w_res;
      if (w_en && w_in[DATA_W-1]) begin
         w_res = {DATA_W{1'b0}};
      end else begin
         w_res = w_in;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/vec_fifo_l4.sv
// DEPTH-entry buffer of whole M-channel vectors. Full/empty come from the
// occupancy count, so the pointers may freely coincide.
module vec_fifo_l4
   import l4_pkg::*;
#(
   parameter int M     = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [M*DATA_W-1:0]       i_wdata,
   output logic [M*DATA_W-1:0]       o_rdata,
   output logic [$clog2(DEPTH):0]    o_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [M*DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [LW-1:0]       r_level;

   // Vector storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Write pointer, wraps DEPTH-1 -> 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PW{1'b0}};
      end else if (i_push) begin
         if (r_wr_ptr == PW'(DEPTH - 1)) begin
            r_wr_ptr <= {PW{1'b0}};
         end else begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
      end
   end

   // Read pointer, wraps DEPTH-1 -> 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= {PW{1'b0}};
      end else if (i_pop) begin
         if (r_rd_ptr == PW'(DEPTH - 1)) begin
            r_rd_ptr <= {PW{1'b0}};
         end else begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= {LW{1'b0}};
      end else begin
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/relu_drain_fifo_l4.sv
// Layer-4 output stage: ReLU on write, vector buffering, and word-serial drain
// of each buffered vector; overflow is flagged because upstream cannot stall.
module relu_drain_fifo_l4
   import l4_pkg::*;
#(
   parameter int M     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [M*DATA_W-1:0]      in_data,
   input  logic                     relu_en,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [ch_w(M)-1:0]       out_ch,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf_err
);

   localparam int CH_W = ch_w(M);
   localparam int LW   = $clog2(DEPTH) + 1;

   logic [M*DATA_W-1:0] w_wdata;
   logic [M*DATA_W-1:0] w_head;
   logic [LW-1:0]       w_level;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_ch_last;
   logic                w_beat;
   logic                w_push;
   logic                w_pop;
   logic [DATA_W-1:0]   w_out_data;
   logic [CH_W-1:0]     r_ch;
   logic                r_ovf_err;

   // ReLU clamp applied per channel before the vector enters storage
   always_comb begin
      w_wdata = {(M*DATA_W){1'b0}};
      for (int i = 0; i < M; i++) begin
         w_wdata[i*DATA_W +: DATA_W] = relu_word(in_data[i*DATA_W +: DATA_W], relu_en);
      end
   end

   // in_ready looks only at the registered level, so a same-cycle pop never frees a slot
   assign w_in_ready  = (w_level < LW'(DEPTH));
   assign w_out_valid = (w_level != {LW{1'b0}});
   assign w_ch_last   = (r_ch == CH_W'(M - 1));
   assign w_beat      = w_out_valid && out_ready;
   assign w_push      = in_valid && w_in_ready;
   assign w_pop       = w_beat && w_ch_last;

   vec_fifo_l4 #(
      .M     (M),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_level (w_level)
   );

   // Channel counter walks the head vector one beat at a time
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ch <= {CH_W{1'b0}};
      end else if (w_beat) begin
         if (w_ch_last) begin
            r_ch <= {CH_W{1'b0}};
         end else begin
            r_ch <= r_ch + CH_W'(1);
         end
      end
   end

   // Sticky overflow flag: a vector arrived with no free slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf_err <= 1'b0;
      end else if (in_valid && !w_in_ready) begin
         r_ovf_err <= 1'b1;
      end
   end

   // Head word select, forced to zero while empty so unwritten storage never leaks out
   always_comb begin
      w_out_data = {DATA_W{1'b0}};
      if (w_out_valid) begin
         w_out_data = w_head[int'(r_ch)*DATA_W +: DATA_W];
      end else begin
         w_out_data = {DATA_W{1'b0}};
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_out_data;
   assign out_ch    = r_ch;
   assign out_last  = w_out_valid && w_ch_last;
   assign level     = w_level;
   assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_relu_drain_fifo_l4.sv
// Directed bench for relu_drain_fifo_l4 with hand-computed expected words.
module tb_relu_drain_fifo_l4;

   localparam int M     = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [127:0]  in_data;
   logic          relu_en;
   logic          in_ready;
   logic          out_valid;
   logic [15:0]   out_data;
   logic [2:0]    out_ch;
   logic          out_last;
   logic          out_ready;
   logic [2:0]    level;
   logic          ovf_err;

   int            n_vec = 0;
   int            n_err = 0;
   logic [15:0]   exp_w [8];
   logic [15:0]   v_a   [8];
   logic [15:0]   v_a_relu [8];

   relu_drain_fifo_l4 #(.M(M), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .relu_en   (relu_en),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last),
      .out_ready (out_ready),
      .level     (level),
      .ovf_err   (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] pack_k(input int k);
      logic [127:0] v;
      v = 128'h0;
      for (int i = 0; i < 8; i++) begin
         v[i*16 +: 16] = 16'(k*256 + i);
      end
      return v;
   endfunction

   task automatic set_exp_k(input int k);
      for (int i = 0; i < 8; i++) begin
         exp_w[i] = 16'(k*256 + i);
      end
   endtask

   task automatic push_k(input int k);
      in_valid = 1'b1;
      in_data  = pack_k(k);
      relu_en  = 1'b0;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      out_ready = 1'b1;
      for (int b = 0; b < n; b++) begin
         check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
         check_val({tag, "_data"},  32'(out_data),  32'(exp_w[b % 8]));
         check_val({tag, "_ch"},    32'(out_ch),    32'(b % 8));
         check_val({tag, "_last"},  32'(out_last),  32'((b % 8) == 7));
         tick();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, "_out_data"},  32'(out_data),  32'd0);
      check_val({tag, "_out_ch"},    32'(out_ch),    32'd0);
      check_val({tag, "_out_last"},  32'(out_last),  32'd0);
      check_val({tag, "_level"},     32'(level),     32'd0);
      check_val({tag, "_ovf"},       32'(ovf_err),   32'd0);
      check_val({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      v_a      = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0003, 16'hFFF0, 16'h0001};
      v_a_relu = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0001};
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 128'h0;
      relu_en   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Single vector with ReLU
      for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = v_a[i];
      out_ready = 1'b1;
      in_valid  = 1'b1;
      relu_en   = 1'b1;
      tick();
      in_valid  = 1'b0;
      check_val("t1_level", 32'(level), 32'd1);
      for (int i = 0; i < 8; i++) exp_w[i] = v_a_relu[i];
      drain(8, "t1");
      check_val("t1_level_end", 32'(level), 32'd0);
      check_val("t1_valid_end", 32'(out_valid), 32'd0);

      // Same vector, pass-through
      in_valid = 1'b1;
      relu_en  = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) exp_w[i] = v_a[i];
      drain(8, "t2");

      // Five back-to-back pushes with no drain
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         check_val("t3_in_ready", 32'(in_ready), 32'(k <= 4));
         in_valid = 1'b1;
         in_data  = pack_k(k);
         tick();
      end
      in_valid = 1'b0;
      check_val("t3_level", 32'(level), 32'd4);
      check_val("t3_ovf",   32'(ovf_err), 32'd1);
      check_val("t3_stall_ch", 32'(out_ch), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         set_exp_k(k);
         drain(8, "t3_drain");
      end
      check_val("t3_level_end", 32'(level), 32'd0);

      // Stalling out_ready 1,0,1,0
      push_k(6);
      set_exp_k(6);
      b = 0;
      for (int cyc = 0; cyc < 16 && b < 8; cyc++) begin
         out_ready = (cyc % 2 == 0);
         check_val("t4_data", 32'(out_data), 32'(exp_w[b]));
         check_val("t4_ch",   32'(out_ch),   32'(b));
         tick();
         if (out_ready) b++;
      end
      check_val("t4_beats", 32'(b), 32'd8);
      check_val("t4_level_end", 32'(level), 32'd0);

      // Push coincident with last-beat pop at level 1
      push_k(7);
      set_exp_k(7);
      drain(7, "t5a_pre");
      check_val("t5a_ch7", 32'(out_ch), 32'd7);
      in_valid = 1'b1;
      in_data  = pack_k(8);
      tick();
      in_valid = 1'b0;
      check_val("t5a_level", 32'(level), 32'd1);
      set_exp_k(8);
      drain(8, "t5a_post");

      // Asynchronous reset mid-drain at ch 3
      push_k(10);
      set_exp_k(10);
      drain(3, "t6_pre");
      check_val("t6_ch3", 32'(out_ch), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      @(negedge clk);
      rst = 1'b1;
      tick();
      push_k(11);
      set_exp_k(11);
      drain(8, "t6_post");
      check_val("t6_ovf", 32'(ovf_err), 32'd0);

      // Push at level 4 in the same cycle as a pop is dropped
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) push_k(k);
      check_val("t5b_level", 32'(level), 32'd4);
      set_exp_k(1);
      drain(7, "t5b_v1");
      check_val("t5b_in_ready", 32'(in_ready), 32'd0);
      check_val("t5b_last", 32'(out_last), 32'd1);
      in_valid = 1'b1;
      in_data  = pack_k(9);
      tick();
      in_valid = 1'b0;
      check_val("t5b_ovf",   32'(ovf_err), 32'd1);
      check_val("t5b_level_pop", 32'(level), 32'd3);
      for (int k = 2; k <= 4; k++) begin
         set_exp_k(k);
         drain(8, "t5b_rest");
      end
      check_val("t5b_level_end", 32'(level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
